// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous RAM between instruction fetch (IF) and
// load/store (MEM). Each access is issued in IDLE, waits out the fixed RAM read
// latency, and completes with a one-cycle ready pulse. Data requests win over
// fetches. A halt request drains outstanding work and then parks the port.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | port free; may issue a data access or a fetch, or park
// D_BUSY | data access in flight; cnt counts down the RAM latency
// I_BUSY | fetch in flight; cnt counts down the RAM latency
// RESP_D | mem_ready pulse; never issues, so the request is not repeated
// RESP_I | if_ready pulse; never issues, so the request is not repeated
// HALTED | parked; requests ignored until reset
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   if_req, if_addr                   fetch request (held until if_ready)
//   if_rdata, if_ready, stall_if      fetch result, completion pulse, IF stall
//   mem_read, mem_write               load/store request levels
//   mem_addr, mem_wdata               load/store address and store data
//   mem_rdata, mem_ready, stall_mem   load result, completion pulse, MEM stall
//   halt_req, halted                  halt request pulse, sticky parked flag
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata              RAM port
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              stall_if,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_mem,
  input  logic              halt_req,
  output logic              halted,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    D_BUSY,
    I_BUSY,
    RESP_D,
    RESP_I,
    HALTED
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             halt_pending;
  logic             d_we;
  logic             issue_d, issue_i;
  logic             issue_ok_d, issue_ok_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      halt_pending <= 1'b0;
      d_we         <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (halt_req) halt_pending <= 1'b1;
      if (issue_d) d_we <= mem_write;
      // stores complete without touching the last load result
      if (state == D_BUSY && cnt == '0 && !d_we) mem_rdata <= ram_rdata;
      if (state == I_BUSY && cnt == '0) if_rdata <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue_d   = 1'b0;
    issue_i   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          issue_d   = 1'b1;
          state_nxt = D_BUSY;
          cnt_nxt   = CNT_INIT;
        end else if (halt_pending || halt_req) begin
          state_nxt = HALTED;
        end else if (if_req) begin
          issue_i   = 1'b1;
          state_nxt = I_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      D_BUSY: begin
        if (cnt == '0) state_nxt = RESP_D;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      I_BUSY: begin
        if (cnt == '0) state_nxt = RESP_I;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP_D:  state_nxt = IDLE;
      RESP_I:  state_nxt = IDLE;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // The strobe is gated by reset so the RAM sees nothing while reset is held,
  // even if a requester keeps its request line up.
  assign issue_ok_d = issue_d & reset_n;
  assign issue_ok_i = issue_i & reset_n;

  assign ram_en    = issue_ok_d | issue_ok_i;
  assign ram_we    = issue_ok_d & mem_write;
  assign ram_addr  = issue_ok_d ? mem_addr : (issue_ok_i ? if_addr : '0);
  assign ram_wdata = issue_ok_d ? mem_wdata : '0;

  assign mem_ready = (state == RESP_D);
  assign if_ready  = (state == RESP_I);
  assign halted    = (state == HALTED);

  assign stall_if  = (if_req & ~if_ready) | halted;
  assign stall_mem = (mem_read | mem_write) & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              stall_if;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_mem;
  logic              halt_req = 1'b0;
  logic              halted;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .stall_if(stall_if),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_mem(stall_mem),
    .halt_req(halt_req), .halted(halted),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Bench RAM: read data is valid only in the cycle MEM_LAT after issue,
  // random garbage otherwise.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] rd_addr = '0;
  int                rd_due = -100;

  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      else begin
        rd_addr = ram_addr;
        rd_due  = cyc + MEM_LAT;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    ram_rdata = (cyc == rd_due) ? ram_mem[rd_addr] : $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"}, {if_rdata, mem_rdata}, 64'h0);
    chk({tag, "_ctl"}, {50'h0, if_ready, mem_ready, halted, ram_en, ram_we, ram_addr}, 64'h0);
    chk({tag, "_wdata"}, {32'h0, ram_wdata}, 64'h0);
  endtask

  task automatic do_reset(input string tag);
    mem_read = 0; mem_write = 0; if_req = 0; halt_req = 0;
    reset_n = 0;
    @(negedge clk);
    check_reset_outputs(tag);
    @(negedge clk);
    reset_n = 1;
    next_cyc();
  endtask

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_we;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // random-phase model state
  bit                d_act, i_act, d_done, i_done, exp_store, exp_en, exp_we, dreq;
  int                busy_kind, done_at, free_at, op, t;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data, last_load;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 9'h020, 32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 9'h020, 32'h0,        1'b0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 9'h030, 32'hA5A5A5A5, 1'b1, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 9'h030, 32'h0,        1'b0, 32'hA5A5A5A5};

    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = $urandom;
    ram_mem[9'h010] = 32'hDEADBEEF;
    ram_mem[9'h040] = 32'h11112222;
    ram_mem[9'h041] = 32'hCAFEF00D;

    do_reset("reset");

    // single accesses from a table
    for (int i = 0; i < 5; i++) begin
      mem_read = vecs[i].rd; mem_write = vecs[i].wr;
      mem_addr = vecs[i].addr; mem_wdata = vecs[i].wdata;
      for (int k = 0; k <= MEM_LAT + 1; k++) begin
        if (k > 0) next_cyc();
        samp();
        chk("tbl_en", {ram_en, ram_we}, (k == 0) ? {1'b1, vecs[i].exp_we} : 2'b00);
        if (k == 0) chk("tbl_addr", {ram_addr, ram_wdata}, {vecs[i].addr, vecs[i].wdata});
        chk("tbl_ready", {mem_ready, stall_mem}, (k == MEM_LAT + 1) ? 2'b10 : 2'b01);
        if (k == MEM_LAT + 1) chk("tbl_rdata", mem_rdata, vecs[i].exp_rdata);
      end
      next_cyc();
      mem_read = 0; mem_write = 0;
      samp();
      chk("tbl_idle", {mem_ready, ram_en}, 2'b00);
      next_cyc();
    end

    // data wins over fetch, fetch follows at the earliest next issue slot
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) next_cyc();
      if (k == 0) begin
        mem_read = 1; mem_addr = 9'h040; if_req = 1; if_addr = 9'h041;
      end
      if (k == 4) mem_read = 0;
      samp();
      chk("prio_en", ram_en, (k == 0 || k == 4));
      if (k == 0) chk("prio_addr0", {ram_we, ram_addr}, {1'b0, 9'h040});
      if (k == 4) chk("prio_addr4", {ram_we, ram_addr}, {1'b0, 9'h041});
      chk("prio_rdy", {mem_ready, if_ready}, {k == 3, k == 7});
      if (k == 3) chk("prio_mem_rdata", mem_rdata, 32'h11112222);
      if (k == 7) chk("prio_if_rdata", if_rdata, 32'hCAFEF00D);
    end
    next_cyc();
    if_req = 0;
    samp();
    chk("prio_idle", {if_ready, ram_en}, 2'b00);
    next_cyc();

    // reset in cycle 1 of a read aborts it
    mem_read = 1; mem_addr = 9'h010;
    samp();
    chk("rst_issue", ram_en, 1'b1);
    next_cyc();
    reset_n = 0;
    #1;
    check_reset_outputs("rst_mid");
    mem_read = 0;
    @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < MEM_LAT + 3; k++) begin
      next_cyc();
      samp();
      chk("rst_noready", {mem_ready, ram_en}, 2'b00);
    end
    next_cyc();
    mem_read = 1; mem_addr = 9'h010;
    for (int k = 0; k <= MEM_LAT + 1; k++) begin
      if (k > 0) next_cyc();
      samp();
      chk("rst_reissue_en", ram_en, k == 0);
      chk("rst_reissue_rdy", mem_ready, k == MEM_LAT + 1);
      if (k == MEM_LAT + 1) chk("rst_reissue_rdata", mem_rdata, 32'hDEADBEEF);
    end
    next_cyc();
    mem_read = 0;
    next_cyc();

    // random traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    last_load = 32'hDEADBEEF;
    d_act = 0; i_act = 0; d_done = 0; i_done = 0;
    busy_kind = 0; done_at = -1; free_at = 0; exp_store = 0; exp_data = '0;
    for (int n = 0; n < 2000; n++) begin
      if (n > 0) next_cyc();
      if (d_act && d_done) begin d_act = 0; mem_read = 0; mem_write = 0; end
      if (i_act && i_done) begin i_act = 0; if_req = 0; end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1;
        op = $urandom_range(0, 2);
        mem_read  = (op != 1);
        mem_write = (op != 0);
        mem_addr  = ADDR_W'($urandom_range(0, 15));
        mem_wdata = $urandom;
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1;
        if_req = 1;
        if_addr = ADDR_W'($urandom_range(0, 15));
      end
      samp();
      t = cyc;
      dreq = mem_read | mem_write;
      d_done = (busy_kind == 1 && t == done_at);
      i_done = (busy_kind == 2 && t == done_at);
      chk("rnd_rdy", {mem_ready, if_ready, stall_mem, stall_if},
          {d_done, i_done, dreq & ~d_done, if_req & ~i_done});
      if (d_done) begin
        if (!exp_store) last_load = exp_data;
        chk("rnd_mem_rdata", mem_rdata, last_load);
      end
      if (i_done) chk("rnd_if_rdata", if_rdata, exp_data);
      exp_en = 0; exp_we = 0; exp_addr = '0;
      if (t >= free_at && (dreq || if_req)) begin
        exp_en = 1;
        if (dreq) begin
          busy_kind = 1;
          exp_we = mem_write;
          exp_addr = mem_addr;
          exp_store = mem_write;
          if (mem_write) ref_mem[mem_addr] = mem_wdata;
          else exp_data = ref_mem[mem_addr];
        end else begin
          busy_kind = 2;
          exp_addr = if_addr;
          exp_data = ref_mem[if_addr];
        end
        done_at = t + MEM_LAT + 1;
        free_at = t + MEM_LAT + 2;
      end
      chk("rnd_ctl", {ram_en, ram_we, ram_addr}, {exp_en, exp_we, exp_addr});
      if (!exp_en || exp_we) chk("rnd_wdata", ram_wdata, exp_en ? mem_wdata : 32'h0);
    end
    next_cyc();
    mem_read = 0; mem_write = 0; if_req = 0;
    repeat (MEM_LAT + 3) next_cyc();

    // halt while a fetch is in flight
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) next_cyc();
      if (k == 0) begin if_req = 1; if_addr = 9'h041; end
      if (k == 1) halt_req = 1;
      if (k == 2) halt_req = 0;
      samp();
      chk("hf_en", ram_en, k == 0);
      chk("hf_rdy", if_ready, k == 3);
      chk("hf_halted", halted, k >= 5);
      chk("hf_stall_if", stall_if, k != 3);
      if (k == 3) chk("hf_if_rdata", if_rdata, 32'hCAFEF00D);
    end
    next_cyc();
    do_reset("rst_after_halt");

    // halt while a load is held: load completes, then park; stores ignored
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) next_cyc();
      if (k == 0) begin mem_read = 1; mem_addr = 9'h020; end
      if (k == 1) halt_req = 1;
      if (k == 2) halt_req = 0;
      if (k == 4) mem_read = 0;
      samp();
      chk("hl_en", ram_en, k == 0);
      chk("hl_rdy", mem_ready, k == 3);
      chk("hl_halted", halted, k >= 5);
      if (k == 3) chk("hl_rdata", mem_rdata, 32'h12345678);
    end
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      if (k == 0) begin mem_write = 1; mem_addr = 9'h050; mem_wdata = 32'h0BADF00D; end
      samp();
      chk("hl_ignored", {ram_en, mem_ready, halted, stall_mem}, 4'b0011);
    end
    next_cyc();
    mem_write = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported synchronous data/instruction RAM between the IF stage (instruction fetch) and the MEM stage (MemRead/MemWrite from the main decoder).
- Sequences each access over the RAM's fixed read latency and returns data to the requester with a ready pulse.
- Drives per-stage stall signals to the pipeline.
- Drains and parks the port when a Halt instruction is requested.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the issue edge until ram_rdata is valid; legal values are 1 or more.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high, with if_addr stable, until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready is high, held until the next if_ready.
- if_ready  out  1  one-cycle completion pulse for fetch.
- stall_if  out  1  IF stall request.
- mem_read  in  1  MEM-stage load request (level).
- mem_write  in  1  MEM-stage store request (level).
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid when mem_ready is high, held until the next mem_ready.
- mem_ready  out  1  one-cycle completion pulse for loads and stores.
- stall_mem  out  1  MEM stall request.
- halt_req  in  1  Halt decoded; a single-cycle pulse is sufficient.
- halted  out  1  port parked; sticky until reset.
- ram_en  out  1  RAM access strobe; high only in an issue cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address; 0 when ram_en is low.
- ram_wdata  out  DATA_W  RAM write data; 0 when ram_en is low.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset: state IDLE, counter 0, halt_pending 0. All outputs are 0: if_rdata, mem_rdata, ready pulses, halted, ram_*.
- Reset taken mid-access aborts the access; no ready pulse is produced.

FSM states: IDLE, D_BUSY, I_BUSY, RESP_D, RESP_I, HALTED.

- IDLE, any data request (mem_read or mem_write) pending:
  - Issue the data access this cycle: ram_en=1, ram_we=mem_write, addr/wdata from the MEM-stage ports.
  - Go to D_BUSY with cnt=MEM_LAT-1.
  - Data always has priority over fetch.
  - If mem_read and mem_write are both high, the access is a write.
- IDLE, no data request, if_req high, and no halt_pending and no halt_req this cycle:
  - Issue the fetch (ram_we=0). Go to I_BUSY with cnt=MEM_LAT-1.
- IDLE, no data request, and halt_pending or halt_req: go to HALTED.
- D_BUSY / I_BUSY:
  - While cnt is nonzero, decrement it.
  - When cnt==0, register ram_rdata into mem_rdata or if_rdata (loads and fetches only; stores leave mem_rdata unchanged). Go to RESP_D or RESP_I.
- RESP_D / RESP_I:
  - Pulse the matching ready for one cycle, then return to IDLE.
  - No issue happens in a RESP state; this guarantees the request that just completed is not re-issued.
- Timing:
  - Issue is cycle 0; ready is at cycle MEM_LAT+1.
  - The earliest next issue is cycle MEM_LAT+2.
- Halt:
  - halt_req sets halt_pending at any state.
  - A fetch already in flight still completes with if_ready.
  - Pending and new data accesses continue to be served until the MEM stage is idle in IDLE.
  - HALTED: halted=1, ram_en=0, all further requests ignored; leave only via reset.
- Stalls:
  - stall_if = (if_req & ~if_ready) | halted.
  - stall_mem = (mem_read|mem_write) & ~mem_ready.
- ram_rdata is sampled only in the capture cycle; its value at other times is don't-care.

Test Plan:
- MEM_LAT=2, mem_read=1, mem_addr=0x010, RAM returns 0xDEADBEEF -> ram_en=1/ram_we=0 at cycle 0; mem_ready=1 at cycle 3 with mem_rdata=0xDEADBEEF; stall_mem high in cycles 0-2.
- mem_write=1, mem_addr=0x020, mem_wdata=0x12345678 -> ram_en=1, ram_we=1, ram_addr=0x020, ram_wdata=0x12345678 at cycle 0; mem_ready at cycle 3; mem_rdata unchanged.
- if_req and mem_read both high in IDLE -> the data access issues first (mem_ready at cycle 3); the fetch issues at cycle 4 with if_ready at cycle 7. if_rdata holds the RAM word for if_addr.
- Fetch in flight, halt_req pulse at cycle 1 -> if_ready still at cycle 3; no further fetch issues; halted=1 from cycle 5, stall_if=1; if_req held high never produces ram_en.
- halt_req while mem_read is held -> the load completes with mem_ready, then halted asserts. A later mem_write is ignored (ram_en stays 0).
- reset_n low at cycle 1 of a read -> all outputs 0 immediately; no mem_ready after release; a fresh request re-issues from IDLE.
